// File: rtl/serial_adder_defs.sv
// rtl/serial_adder_defs.sv - shared state encoding and counter sizing for serial_chunk_adder
package serial_adder_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter never narrower than one bit, so WORDS=1 still has a legal counter.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder_cin.sv
// rtl/chunk_adder_cin.sv - combinational ripple-carry chunk adder with carry-in
// Optional OVERFLOW_FLAG_EN exposes the carry into the MSB for signed overflow detection.
module chunk_adder_cin #(
    parameter int DATA_WIDTH = 3
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_cin,
    output logic [DATA_WIDTH-1:0] o_sum,
`ifdef OVERFLOW_FLAG_EN
    output logic                  o_cmsb,
`endif
    output logic                  o_cout
);

    logic [DATA_WIDTH:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[DATA_WIDTH];
`ifdef OVERFLOW_FLAG_EN
    assign o_cmsb = w_c[DATA_WIDTH-1];
`endif

endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - wide adder processing one DATA_WIDTH chunk per cycle, LSB first
// Optional OVERFLOW_FLAG_EN adds a registered signed-overflow output.
module serial_chunk_adder
    import serial_adder_defs::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int WORDS      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*WORDS-1:0] a,
    input  logic [DATA_WIDTH*WORDS-1:0] b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*WORDS-1:0] sum,
    output logic                        carry,
`ifdef OVERFLOW_FLAG_EN
    output logic                        overflow,
`endif
    output logic                        busy
);

    localparam int W  = DATA_WIDTH * WORDS;
    localparam int CW = cnt_width(WORDS);

    state_t                r_state;
    logic [W-1:0]          r_a_sh;
    logic [W-1:0]          r_b_sh;
    logic                  r_c;
    logic [CW-1:0]         r_cnt;
    logic [W-1:0]          r_sum;
    logic                  r_carry;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] w_chunk;
    logic                  w_cout;
`ifdef OVERFLOW_FLAG_EN
    logic                  w_cmsb;
    logic                  r_ovf;
`endif

    chunk_adder_cin #(.DATA_WIDTH(DATA_WIDTH)) u_chunk (
        .i_a   (r_a_sh[DATA_WIDTH-1:0]),
        .i_b   (r_b_sh[DATA_WIDTH-1:0]),
        .i_cin (r_c),
        .o_sum (w_chunk),
`ifdef OVERFLOW_FLAG_EN
        .o_cmsb(w_cmsb),
`endif
        .o_cout(w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[32'(r_cnt)*DATA_WIDTH +: DATA_WIDTH] <= w_chunk;
                    r_c    <= w_cout;
                    r_a_sh <= r_a_sh >> DATA_WIDTH;
                    r_b_sh <= r_b_sh >> DATA_WIDTH;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WORDS - 1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_carry     <= w_cout;
`ifdef OVERFLOW_FLAG_EN
                        r_ovf       <= w_cout ^ w_cmsb;
`endif
                    end
                end
                DONE: begin
                    // Result registers are left untouched so sum/carry persist until the next accept.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
`ifdef OVERFLOW_FLAG_EN
    assign overflow  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - self-checking bench for serial_chunk_adder (DATA_WIDTH=3, WORDS=4)
module tb_serial_chunk_adder;

    localparam int DW = 3;
    localparam int WD = 4;
    localparam int W  = DW * WD;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry;
    logic         busy;
`ifdef OVERFLOW_FLAG_EN
    logic         overflow;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_accept = -100;
    bit prev_fast   = 1'b0;

    serial_chunk_adder #(.DATA_WIDTH(DW), .WORDS(WD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry    (carry),
`ifdef OVERFLOW_FLAG_EN
        .overflow (overflow),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: reference result is the plain 13-bit sum; hold = cycles of out_ready=0 after out_valid.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold, input bit chk_space);
        logic [W:0] ref_full;
        int lat;
        int acc;
        ref_full  = {1'b0, ta} + {1'b0, tb_};
        out_ready = (hold == 0);
        check("in_ready_before", in_ready, 1);
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        if (chk_space && prev_fast) check("accept_spacing", acc - last_accept, WD + 2);
        last_accept = acc;
        prev_fast = (hold == 0);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check("busy_run", busy, 1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        lat = out_valid ? lat - 1 : lat;
        check("latency", lat, WD);
        check("sum", sum, ref_full[W-1:0]);
        check("carry", carry, ref_full[W]);
`ifdef OVERFLOW_FLAG_EN
        check("overflow", overflow, (ta[W-1] == tb_[W-1]) && (ref_full[W-1] != ta[W-1]));
`endif
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 0);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, ref_full[W-1:0]);
            check("hold_carry", carry, ref_full[W]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", out_valid, 0);
        check("idle_ready", in_ready, 1);
        check("sum_kept", sum, ref_full[W-1:0]);
    endtask

    initial begin
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_no_capture", busy, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(12'h001, 12'h001, 0, 1'b0);
        run_op(12'hFFF, 12'h001, 0, 1'b1);
        run_op(12'hABC, 12'h765, 10, 1'b0);

        // Abort during the second RUN cycle.
        a = 12'hFFF;
        b = 12'hFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(12'h123, 12'h456, 0, 1'b0);

        run_op(12'h7FF, 12'h001, 0, 1'b1);
        run_op(12'h800, 12'h800, 0, 1'b1);
        run_op(12'h000, 12'h000, 0, 1'b1);

        for (int k = 0; k < 1000; k++) begin
            int h;
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(W'($urandom), W'($urandom), h, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
